keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter NUM_ROWS, default 4: number of row sense inputs; legal range 1..8.
REQ-002 Parameter NUM_COLS, default 3: number of column drive outputs; legal range 1..8.
REQ-003 Parameter SCAN_DIV, default 1024: clock cycles each column is driven during scanning; minimum 4.
REQ-004 Parameter DB_CNT, default 16: consecutive stable cycles required to accept a press or a release; minimum 2.
REQ-005 Parameter REPEAT_DLY, default 65536: auto-repeat interval in cycles; used only when KEYPAD_REPEAT_EN is defined.
REQ-006 clk  input  1  single system clock; all logic is on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 row  input  NUM_ROWS  raw, asynchronous, active-high row sense lines.
REQ-009 col  output  NUM_COLS  one-hot column drive.
REQ-010 key_code  output  CODE_W  code of the accepted key, where CODE_W = clog2(NUM_ROWS*NUM_COLS) with a minimum of 1.
REQ-011 key_valid  output  1  one-cycle strobe marking a new key_code.
REQ-012 key_held  output  1  level; high while an accepted key is held.

Function
REQ-013 row SHALL pass through a 2-flop synchroniser; all decisions use the synchronised value (srow), giving 2 cycles of latency.
REQ-014 FSM states SHALL be SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-015 SCAN: col SHALL dwell SCAN_DIV cycles per column, then advance index+1, wrapping from NUM_COLS-1 to 0.
REQ-016 SCAN: on the last dwell cycle, if srow is exactly one-hot, the block SHALL capture the column index and row index, freeze col, and enter DEBOUNCE.
REQ-017 SCAN: if srow is zero or has more than one bit set, the block SHALL stay in SCAN; multi-row (ghost) patterns are never reported.
REQ-018 DEBOUNCE: after DB_CNT consecutive cycles with srow equal to the captured pattern, the block SHALL enter PRESSED.
REQ-019 DEBOUNCE: any mismatch SHALL return the block to SCAN with the column advanced, and SHALL NOT pulse key_valid.
REQ-020 On entry to PRESSED, key_code SHALL equal col_idx*NUM_ROWS + row_idx, and key_valid SHALL pulse in that same cycle.
REQ-021 key_held SHALL be high throughout PRESSED and RELEASE.
REQ-022 PRESSED: when srow is zero, the block SHALL enter RELEASE.
REQ-023 PRESSED: any nonzero srow, including a different key, SHALL be treated as still held and SHALL NOT produce a new code.
REQ-024 RELEASE: after DB_CNT consecutive zero cycles, the block SHALL drop key_held and return to SCAN at the next column.
REQ-025 RELEASE: any nonzero srow SHALL return the block to PRESSED without a key_valid pulse.
REQ-026 key_code SHALL hold its last value until the next accepted key.
REQ-027 key_valid SHALL never be high for two consecutive cycles.

Reset
REQ-028 Asserting reset SHALL immediately set: col = 1 (column 0), key_code = 0, key_valid = 0, key_held = 0, state = SCAN, and all counters and synchronisers = 0.
REQ-029 Reset asserted mid-DEBOUNCE or mid-PRESSED SHALL discard the pending key, and no key_valid pulse SHALL follow deassertion unless a new press is fully accepted.

Configuration
REQ-030 When KEYPAD_REPEAT_EN is defined, the block SHALL pulse key_valid again in PRESSED with the same key_code after REPEAT_DLY cycles of continuous hold, then every REPEAT_DLY cycles.
REQ-031 While KEYPAD_REPEAT_EN is defined, a visit to RELEASE SHALL restart the repeat counter.
REQ-032 When KEYPAD_REPEAT_EN is not defined, the block SHALL produce exactly one key_valid pulse per press, and the repeat counter SHALL not exist.

Structure
REQ-033 Package keypad_pkg SHALL hold the FSM state enum, the CODE_W computation function, and the minimum-value constants for the parameters.
REQ-034 Sub-module keypad_sync SHALL implement the parametrised-width 2-flop synchroniser with asynchronous reset.

Verification
Bench parameters: NUM_ROWS=4, NUM_COLS=3, SCAN_DIV=4, DB_CNT=3, REPEAT_DLY=20.
REQ-035 Clean press of col 1 / row 0 held for 40 cycles -> exactly one key_valid with key_code=4; key_held rises; key_held falls DB_CNT+2 cycles after row release.
REQ-036 Clean press of col 2 / row 3 -> key_code=11; then col 0 / row 3 -> key_code=3.
REQ-037 row bit 1 toggling every 2 cycles during DEBOUNCE -> no key_valid, and col keeps rotating 1->2->4->1.
REQ-038 row=4'b0101 asserted in col 0 -> no key_valid and no change to key_held over 100 cycles.
REQ-039 reset pulsed in the second DEBOUNCE cycle of a col 0 / row 2 press -> col=3'b001 immediately, key_code=0, no key_valid within 10 cycles after release of reset and key.
REQ-040 With KEYPAD_REPEAT_EN defined, col 0 / row 1 held for 70 cycles after acceptance -> key_valid pulses with key_code=1 at acceptance, +20, +40 and +60 cycles; without the macro, a single pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner: FSM state encoding,
// code-width computation and parameter limits.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int MIN_ROWS       = 1;
  localparam int MAX_ROWS       = 8;
  localparam int MIN_COLS       = 1;
  localparam int MAX_COLS       = 8;
  localparam int MIN_SCAN_DIV   = 4;
  localparam int MIN_DB_CNT     = 2;
  localparam int MIN_REPEAT_DLY = 2;

  // Bits needed to index 'n' items, never less than one.
  function automatic int code_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for a bus of independent asynchronous level inputs.
module keypad_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments keep meta->q a true two-stage pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// Keypad column scanner with debounce, ghost rejection and press/release tracking.
// Build macro KEYPAD_REPEAT_EN adds periodic key_valid strobes while a key is held.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS   = 4,
  parameter int NUM_COLS   = 3,
  parameter int SCAN_DIV   = 1024,
  parameter int DB_CNT     = 16,
  parameter int REPEAT_DLY = 65536,
  localparam int CODE_W    = code_width(NUM_ROWS * NUM_COLS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam int ROW_W = code_width(NUM_ROWS);
  localparam int COL_W = code_width(NUM_COLS);
  localparam int DIV_W = code_width(SCAN_DIV);
  localparam int DB_W  = code_width(DB_CNT);

  if (NUM_ROWS < MIN_ROWS || NUM_ROWS > MAX_ROWS ||
      NUM_COLS < MIN_COLS || NUM_COLS > MAX_COLS ||
      SCAN_DIV < MIN_SCAN_DIV || DB_CNT < MIN_DB_CNT ||
      REPEAT_DLY < MIN_REPEAT_DLY) begin : g_param_check
    $error("keypad_scan: parameter out of range");
  end

  state_t              state, state_nxt;
  logic [NUM_ROWS-1:0] srow, cap_row;
  logic [ROW_W-1:0]    row_idx, srow_idx;
  logic [COL_W-1:0]    col_idx, col_idx_nxt;
  logic [DIV_W-1:0]    dwell_cnt;
  logic [DB_W-1:0]     db_cnt;
  logic                srow_zero, srow_onehot, last_dwell;
  logic                db_match, db_done, accept, rep_fire;

  keypad_sync #(.WIDTH(NUM_ROWS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row),
    .q     (srow)
  );

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    srow_idx = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (srow[i]) srow_idx = ROW_W'(i);
    end
  end

  assign srow_zero   = (srow == '0);
  assign srow_onehot = !srow_zero && ((srow & (srow - 1'b1)) == '0);
  assign last_dwell  = (dwell_cnt == DIV_W'(SCAN_DIV - 1));
  assign db_match    = (srow == cap_row);
  assign db_done     = (db_cnt == DB_W'(DB_CNT - 1));
  assign accept      = (state == DEBOUNCE) && db_match && db_done;
  assign col_idx_nxt = (col_idx == COL_W'(NUM_COLS - 1)) ? '0 : col_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SCAN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCAN:     if (last_dwell && srow_onehot) state_nxt = DEBOUNCE;
      DEBOUNCE: if (!db_match)                 state_nxt = SCAN;
                else if (db_done)              state_nxt = PRESSED;
      PRESSED:  if (srow_zero)                 state_nxt = RELEASE;
      RELEASE:  if (!srow_zero)                state_nxt = PRESSED;
                else if (db_done)              state_nxt = SCAN;
    endcase
  end

  always_comb begin
    col      = NUM_COLS'(1) << col_idx;
    key_held = (state == PRESSED) || (state == RELEASE);
  end

  // The capture cycle and the first zero cycle in PRESSED both count as the
  // first stable cycle, so db_cnt starts at 1 on entry to DEBOUNCE/RELEASE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_idx   <= '0;
      dwell_cnt <= '0;
      db_cnt    <= '0;
      cap_row   <= '0;
      row_idx   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= accept || rep_fire;
      if (accept) key_code <= CODE_W'(int'(col_idx) * NUM_ROWS + int'(row_idx));
      case (state)
        SCAN: begin
          if (last_dwell) begin
            dwell_cnt <= '0;
            if (srow_onehot) begin
              cap_row <= srow;
              row_idx <= srow_idx;
              db_cnt  <= DB_W'(1);
            end else begin
              col_idx <= col_idx_nxt;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!db_match)     col_idx <= col_idx_nxt;
          else if (!db_done) db_cnt  <= db_cnt + 1'b1;
        end
        PRESSED: begin
          if (srow_zero) db_cnt <= DB_W'(1);
        end
        RELEASE: begin
          if (srow_zero) begin
            if (db_done) begin
              col_idx   <= col_idx_nxt;
              dwell_cnt <= '0;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = code_width(REPEAT_DLY);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_done;

  assign rep_done = (rep_cnt == REP_W'(REPEAT_DLY - 1));
  assign rep_fire = (state == PRESSED) && !srow_zero && rep_done;

  // Any cycle outside PRESSED (including a RELEASE bounce) restarts the interval.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  rep_cnt <= '0;
    else if (state != PRESSED)  rep_cnt <= '0;
    else if (rep_done)          rep_cnt <= '0;
    else                        rep_cnt <= rep_cnt + 1'b1;
  end
`else
  assign rep_fire = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Directed self-checking bench for keypad_scan; a small keypad model drives
// row from the scanned col, with a force path for ghost/bounce patterns.
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row;
  logic [2:0] col;
  logic [3:0] key_code;
  logic       key_valid, key_held;

  int total = 0;
  int bad   = 0;

  bit         force_en = 1'b0;
  logic [3:0] force_row = '0;
  bit         k_on = 1'b0, k2_on = 1'b0;
  int         k_col = 0, k_row = 0, k2_col = 0, k2_row = 0;
  logic       prev_valid = 1'b0;

  keypad_scan #(
    .NUM_ROWS   (4),
    .NUM_COLS   (3),
    .SCAN_DIV   (4),
    .DB_CNT     (3),
    .REPEAT_DLY (20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // A pressed key closes its row only while its column is driven.
  always_comb begin
    row = force_en ? force_row : 4'b0000;
    if (!force_en) begin
      if (k_on && col[k_col])   row[k_row]  = 1'b1;
      if (k2_on && col[k2_col]) row[k2_row] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (key_valid) begin
      total++;
      if (prev_valid) begin
        bad++;
        $display("FAIL valid_strobe: key_valid=1 in two consecutive cycles, required single-cycle");
      end
    end
    prev_valid = key_valid;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_col_enter(input logic [2:0] target);
    int n = 0;
    while (col == target && n < 40) begin @(negedge clk); n++; end
    while (col != target && n < 40) begin @(negedge clk); n++; end
    total++;
    if (col !== target) begin
      bad++;
      $display("FAIL col_enter: col=%b required %b within 40 cycles", col, target);
    end
  endtask

  task automatic press_and_wait(input int c, input int r, output logic [3:0] code);
    int n = 0;
    k_col = c; k_row = r; k_on = 1'b1;
    code = 'x;
    while (n < 60) begin
      @(negedge clk); n++;
      if (key_valid) begin code = key_code; break; end
    end
    total++;
    if (!key_valid) begin
      bad++;
      $display("FAIL press_timeout: no key_valid for col %0d row %0d in 60 cycles", c, r);
    end
  endtask

  task automatic release_key();
    int n = 0;
    k_on = 1'b0; k2_on = 1'b0;
    while (key_held && n < 20) begin @(negedge clk); n++; end
    total++;
    if (key_held !== 1'b0) begin
      bad++;
      $display("FAIL release_timeout: key_held=%b required 0 within 20 cycles", key_held);
    end
  endtask

  task automatic test_reset();
    #1;
    total += 4;
    if (col !== 3'b001)      begin bad++; $display("FAIL reset_col: got %b need 001", col); end
    if (key_code !== 4'd0)   begin bad++; $display("FAIL reset_code: got %0d need 0", key_code); end
    if (key_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid: got %b need 0", key_valid); end
    if (key_held !== 1'b0)   begin bad++; $display("FAIL reset_held: got %b need 0", key_held); end
    cyc(3);
    reset = 1'b0;
  endtask

  task automatic test_clean_press();
    int first = 0, extra = 0, held_low = 0, exp_extra;
    logic [3:0] code_at = '0;
    logic held_at = 1'b0, held_pre = 1'b1;
`ifdef KEYPAD_REPEAT_EN
    exp_extra = 2;
`else
    exp_extra = 0;
`endif
    wait_col_enter(3'b010);
    k_col = 1; k_row = 0; k_on = 1'b1;
    for (int i = 1; i <= 10 && first == 0; i++) begin
      @(negedge clk);
      if (key_valid) begin first = i; code_at = key_code; held_at = key_held; end
      else held_pre = key_held;
    end
    total += 4;
    if (first !== 6)       begin bad++; $display("FAIL press_latency: valid after %0d cycles need 6", first); end
    if (code_at !== 4'd4)  begin bad++; $display("FAIL press_code: got %0d need 4", code_at); end
    if (held_at !== 1'b1)  begin bad++; $display("FAIL press_held_rise: got %b need 1", held_at); end
    if (held_pre !== 1'b0) begin bad++; $display("FAIL press_held_early: got %b need 0", held_pre); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (key_valid) extra++;
      if (!key_held) held_low++;
    end
    total += 2;
    if (extra !== exp_extra) begin bad++; $display("FAIL hold_pulses: got %0d need %0d", extra, exp_extra); end
    if (held_low !== 0)      begin bad++; $display("FAIL hold_level: key_held low %0d cycles need 0", held_low); end
    k_on = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      total++;
      if (key_held !== (i < 5)) begin
        bad++;
        $display("FAIL held_fall: cycle %0d after release key_held=%b need %b", i, key_held, (i < 5));
      end
    end
    cyc(5);
    total++;
    if (key_code !== 4'd4) begin bad++; $display("FAIL code_hold: got %0d need 4", key_code); end
  endtask

  task automatic test_two_keys();
    logic [3:0] code;
    press_and_wait(2, 3, code);
    total++;
    if (code !== 4'd11) begin bad++; $display("FAIL key_c2r3: got %0d need 11", code); end
    release_key();
    total++;
    if (key_code !== 4'd11) begin bad++; $display("FAIL code_after_release: got %0d need 11", key_code); end
    press_and_wait(0, 3, code);
    total++;
    if (code !== 4'd3) begin bad++; $display("FAIL key_c0r3: got %0d need 3", code); end
    release_key();
  endtask

  task automatic test_bounce();
    logic [3:0] code;
    int pulses = 0, held_low = 0;
    press_and_wait(1, 2, code);
    total++;
    if (code !== 4'd6) begin bad++; $display("FAIL key_c1r2: got %0d need 6", code); end
    k2_col = 1; k2_row = 0; k2_on = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
      if (!key_held) held_low++;
      if (i == 5) k2_on = 1'b0;
      if (i == 6) k_on = 1'b0;
      if (i == 7) k_on = 1'b1;
    end
    total += 3;
    if (pulses !== 0)      begin bad++; $display("FAIL bounce_valid: got %0d pulses need 0", pulses); end
    if (held_low !== 0)    begin bad++; $display("FAIL bounce_held: key_held low %0d cycles need 0", held_low); end
    if (key_code !== 4'd6) begin bad++; $display("FAIL bounce_code: got %0d need 6", key_code); end
    release_key();
  endtask

  task automatic test_ghost_toggle();
    int pulses = 0, moves = 0;
    logic [2:0] prev_col, exp_col;
    force_en = 1'b1; force_row = 4'b0010;
    prev_col = col;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
      if (col !== prev_col) begin
        exp_col = {prev_col[1:0], prev_col[2]};
        moves++;
        total++;
        if (col !== exp_col) begin bad++; $display("FAIL toggle_rotate: col %b -> %b need %b", prev_col, col, exp_col); end
        prev_col = col;
      end
      if (i % 2 == 1) force_row = force_row ^ 4'b0010;
    end
    force_en = 1'b0; force_row = '0;
    total += 2;
    if (pulses !== 0) begin bad++; $display("FAIL toggle_valid: got %0d pulses need 0", pulses); end
    if (moves < 3)    begin bad++; $display("FAIL toggle_moves: got %0d column moves need >=3", moves); end
    cyc(4);
  endtask

  task automatic test_ghost_multi();
    int pulses = 0, held_hi = 0;
    wait_col_enter(3'b001);
    force_en = 1'b1; force_row = 4'b0101;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
      if (key_held) held_hi++;
    end
    force_en = 1'b0; force_row = '0;
    total += 2;
    if (pulses !== 0) begin bad++; $display("FAIL ghost_valid: got %0d pulses need 0", pulses); end
    if (held_hi !== 0) begin bad++; $display("FAIL ghost_held: key_held high %0d cycles need 0", held_hi); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    wait_col_enter(3'b001);
    k_col = 0; k_row = 2; k_on = 1'b1;
    cyc(5);
    reset = 1'b1;
    #1;
    total += 4;
    if (col !== 3'b001)     begin bad++; $display("FAIL mid_reset_col: got %b need 001", col); end
    if (key_code !== 4'd0)  begin bad++; $display("FAIL mid_reset_code: got %0d need 0", key_code); end
    if (key_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b need 0", key_valid); end
    if (key_held !== 1'b0)  begin bad++; $display("FAIL mid_reset_held: got %b need 0", key_held); end
    cyc(2);
    k_on = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL mid_reset_pulse: got %0d pulses need 0", pulses); end
  endtask

  task automatic test_repeat();
    logic [3:0] code;
    int offs[$];
    int exp_n;
`ifdef KEYPAD_REPEAT_EN
    exp_n = 3;
`else
    exp_n = 0;
`endif
    press_and_wait(0, 1, code);
    total++;
    if (code !== 4'd1) begin bad++; $display("FAIL repeat_first_code: got %0d need 1", code); end
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (key_valid) begin
        offs.push_back(i);
        total++;
        if (key_code !== 4'd1) begin bad++; $display("FAIL repeat_code: got %0d need 1", key_code); end
      end
    end
    total++;
    if (offs.size() !== exp_n) begin bad++; $display("FAIL repeat_count: got %0d pulses need %0d", offs.size(), exp_n); end
    else begin
      foreach (offs[j]) begin
        total++;
        if (offs[j] !== 20 * (j + 1)) begin bad++; $display("FAIL repeat_offset: pulse %0d at +%0d need +%0d", j, offs[j], 20 * (j + 1)); end
      end
    end
    release_key();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_two_keys();
    test_bounce();
    test_ghost_toggle();
    test_ghost_multi();
    test_reset_mid();
    test_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
